// File: rtl/fisr_axil_slave_regs.sv
// AXI4-Lite slave register front-end for the FISR controller.
// Holds the float32 operand, launches the core with a one-cycle start pulse,
// tracks busy/done and captures the core result for readback.
module fisr_axil_slave_regs #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  // Write address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  // Write data channel
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  // Write response channel
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  // Read address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  // Read data channel
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  // FISR core interface
  output logic                            core_start,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   core_x,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   core_result,
  input  logic                            core_valid
);

  localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
  localparam int unsigned StrbW = C_S_AXI_DATA_WIDTH / 8;

  localparam logic [1:0] IdxXIn   = 2'd0;
  localparam logic [1:0] IdxCtrl  = 2'd1;
  localparam logic [1:0] IdxStat  = 2'd2;
  localparam logic [1:0] IdxResult = 2'd3;

  // Ready outputs stay low for the first cycle out of reset.
  logic             ready_en_q;
  logic             aw_full_q, aw_full_d;
  logic [1:0]       aw_idx_q, aw_idx_d;
  logic             w_full_q, w_full_d;
  logic [DW-1:0]    w_data_q, w_data_d;
  logic [StrbW-1:0] w_strb_q, w_strb_d;
  logic             bvalid_q, bvalid_d;
  logic             rvalid_q, rvalid_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [DW-1:0]    x_in_q, x_in_d;
  logic [DW-1:0]    result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             core_start_q, core_start_d;

  logic             awready, wready, arready;
  logic             aw_hs, w_hs, ar_hs, commit;
  logic [1:0]       wr_idx;
  logic [DW-1:0]    wr_data;
  logic [StrbW-1:0] wr_strb;
  logic             start_req, w1c_done;
  logic [DW-1:0]    rd_mux;

  assign awready = ready_en_q & ~aw_full_q & ~bvalid_q;
  assign wready  = ready_en_q & ~w_full_q & ~bvalid_q;
  assign arready = ready_en_q & ~rvalid_q;

  assign aw_hs = S_AXI_AWVALID & awready;
  assign w_hs  = S_AXI_WVALID & wready;
  assign ar_hs = S_AXI_ARVALID & arready;

  // Commit once both halves are held or arriving this cycle.
  assign commit  = (aw_full_q | aw_hs) & (w_full_q | w_hs);
  assign wr_idx  = aw_full_q ? aw_idx_q : S_AXI_AWADDR[3:2];
  assign wr_data = w_full_q ? w_data_q : S_AXI_WDATA;
  assign wr_strb = w_full_q ? w_strb_q : S_AXI_WSTRB;

  assign start_req = commit & (wr_idx == IdxCtrl) & wr_data[0] & ~busy_q;
  assign w1c_done  = commit & (wr_idx == IdxStat) & wr_data[1];

  // Write-channel hold registers and response handshake.
  always_comb begin
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
    end else begin
      if (aw_hs) begin
        aw_full_d = 1'b1;
        aw_idx_d  = S_AXI_AWADDR[3:2];
      end
      if (w_hs) begin
        w_full_d = 1'b1;
        w_data_d = S_AXI_WDATA;
        w_strb_d = S_AXI_WSTRB;
      end
      if (bvalid_q && S_AXI_BREADY) begin
        bvalid_d = 1'b0;
      end
    end
  end

  // Register file update; ordering gives W1C < core set < start priority.
  always_comb begin
    x_in_d       = x_in_q;
    result_d     = result_q;
    busy_d       = busy_q;
    done_d       = done_q;
    core_start_d = start_req;
    if (commit && (wr_idx == IdxXIn)) begin
      for (int unsigned i = 0; i < StrbW; i++) begin
        if (wr_strb[i]) begin
          x_in_d[8*i +: 8] = wr_data[8*i +: 8];
        end
      end
    end
    if (w1c_done) begin
      done_d = 1'b0;
    end
    if (core_valid) begin
      result_d = core_result;
      if (busy_q) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
    if (start_req) begin
      busy_d = 1'b1;
      done_d = 1'b0;
    end
  end

  // Read decode from pre-update register values.
  always_comb begin
    rd_mux = '0;
    unique case (S_AXI_ARADDR[3:2])
      IdxXIn:    rd_mux = x_in_q;
      IdxCtrl:   rd_mux = '0;
      IdxStat:   rd_mux = {{(DW-2){1'b0}}, done_q, busy_q};
      IdxResult: rd_mux = result_q;
      default:   rd_mux = '0;
    endcase
  end

  // Read channel: capture on AR handshake, hold until RREADY.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ready_en_q   <= 1'b0;
      aw_full_q    <= 1'b0;
      aw_idx_q     <= '0;
      w_full_q     <= 1'b0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      bvalid_q     <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      x_in_q       <= '0;
      result_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      core_start_q <= 1'b0;
    end else begin
      ready_en_q   <= 1'b1;
      aw_full_q    <= aw_full_d;
      aw_idx_q     <= aw_idx_d;
      w_full_q     <= w_full_d;
      w_data_q     <= w_data_d;
      w_strb_q     <= w_strb_d;
      bvalid_q     <= bvalid_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      x_in_q       <= x_in_d;
      result_q     <= result_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      core_start_q <= core_start_d;
    end
  end

  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = wready;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RVALID  = rvalid_q;
  assign core_start    = core_start_q;
  assign core_x        = x_in_q;

  // Protection bits and non-decoded address bits are intentionally ignored.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

endmodule
